nf_sume_xbar_rr_arbiter: RTL and testbench

NF_SUME_XBAR_RR_ARBITER -- requirements
Module: nf_sume_xbar_rr_arbiter

---
 rtl/nf_sume_xbar_pkg.sv | 13 +
 rtl/xbar_rr_pick.sv | 37 +++
 rtl/nf_sume_xbar_rr_arbiter.sv | 108 ++++++++++
 tb/tb_nf_sume_xbar_rr_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nf_sume_xbar_pkg.sv
// Shared definitions for the NetFPGA SUME crossbar round-robin arbiter:
// FSM state encoding, packet counter width and the default requester count.
package nf_sume_xbar_pkg;

  localparam int PKT_COUNT_WIDTH    = 32;
  localparam int DEFAULT_NUM_QUEUES = 5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } xbar_state_e;

endpackage

// File: rtl/xbar_rr_pick.sv
// Combinational round-robin search: returns, one-hot, the first eligible
// requester found scanning upward from the one after the previous winner.
module xbar_rr_pick
  import nf_sume_xbar_pkg::*;
#(
  parameter int NUM_QUEUES = DEFAULT_NUM_QUEUES,
  parameter int IDX_W      = $clog2(NUM_QUEUES)
) (
  input  logic [NUM_QUEUES-1:0] i_req,
  input  logic [NUM_QUEUES-1:0] i_enable,
  input  logic [IDX_W-1:0]      i_last_grant,
  output logic [NUM_QUEUES-1:0] o_grant,
  output logic                  o_any_req
);

  logic [NUM_QUEUES-1:0] w_elig;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_found;

  assign w_elig    = i_req & i_enable;
  assign o_any_req = |w_elig;

  // Offsets 1..NUM_QUEUES visit every requester once, ending on last_grant itself.
  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 1; k <= NUM_QUEUES; k++) begin
      w_idx = IDX_W'((int'(i_last_grant) + k) % NUM_QUEUES);
      if (!w_found && w_elig[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        w_found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/nf_sume_xbar_rr_arbiter.sv
// Packet-level round-robin AXI-Stream arbiter: one requester owns the master
// stream from its first beat to its tlast, with one arbitration cycle between.
module nf_sume_xbar_rr_arbiter
  import nf_sume_xbar_pkg::*;
#(
  parameter int C_AXIS_DATA_WIDTH  = 64,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int NUM_QUEUES         = DEFAULT_NUM_QUEUES
) (
  input  logic                                          axis_aclk,
  input  logic                                          axis_aresetn,
  input  logic [NUM_QUEUES*C_AXIS_DATA_WIDTH-1:0]       s_axis_tdata,
  input  logic [NUM_QUEUES*(C_AXIS_DATA_WIDTH/8)-1:0]   s_axis_tkeep,
  input  logic [NUM_QUEUES*C_AXIS_TUSER_WIDTH-1:0]      s_axis_tuser,
  input  logic [NUM_QUEUES-1:0]                         s_axis_tvalid,
  input  logic [NUM_QUEUES-1:0]                         s_axis_tlast,
  output logic [NUM_QUEUES-1:0]                         s_axis_tready,
  output logic [C_AXIS_DATA_WIDTH-1:0]                  m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]                m_axis_tkeep,
  output logic [C_AXIS_TUSER_WIDTH-1:0]                 m_axis_tuser,
  output logic                                          m_axis_tvalid,
  output logic                                          m_axis_tlast,
  input  logic                                          m_axis_tready,
  input  logic [NUM_QUEUES-1:0]                         port_enable,
  output logic [PKT_COUNT_WIDTH-1:0]                    pkt_count,
  output logic [NUM_QUEUES-1:0]                         cur_grant
);

  localparam int KEEP_W = C_AXIS_DATA_WIDTH / 8;
  localparam int IDX_W  = $clog2(NUM_QUEUES);

  xbar_state_e                r_state;
  logic [NUM_QUEUES-1:0]      r_grant;
  logic [IDX_W-1:0]           r_last_grant;
  logic [PKT_COUNT_WIDTH-1:0] r_pkt_count;

  logic [NUM_QUEUES-1:0]      w_next_grant;
  logic                       w_any_req;
  logic [IDX_W-1:0]           w_grant_idx;
  logic                       w_pkt_done;

  xbar_rr_pick #(
    .NUM_QUEUES (NUM_QUEUES),
    .IDX_W      (IDX_W)
  ) u_pick (
    .i_req        (s_axis_tvalid),
    .i_enable     (port_enable),
    .i_last_grant (r_last_grant),
    .o_grant      (w_next_grant),
    .o_any_req    (w_any_req)
  );

  always_comb begin
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tuser  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    w_grant_idx   = '0;
    for (int i = 0; i < NUM_QUEUES; i++) begin
      if (r_state == ST_SEND && r_grant[i]) begin
        m_axis_tdata  = s_axis_tdata[i*C_AXIS_DATA_WIDTH +: C_AXIS_DATA_WIDTH];
        m_axis_tkeep  = s_axis_tkeep[i*KEEP_W +: KEEP_W];
        m_axis_tuser  = s_axis_tuser[i*C_AXIS_TUSER_WIDTH +: C_AXIS_TUSER_WIDTH];
        m_axis_tvalid = s_axis_tvalid[i];
        m_axis_tlast  = s_axis_tlast[i];
        w_grant_idx   = IDX_W'(i);
      end
    end
  end

  assign s_axis_tready = (r_state == ST_SEND) ? (r_grant & {NUM_QUEUES{m_axis_tready}}) : '0;
  assign w_pkt_done    = m_axis_tvalid & m_axis_tready & m_axis_tlast;
  assign cur_grant     = r_grant;
  assign pkt_count     = r_pkt_count;

  // port_enable is only sampled when arbitrating, so a packet in flight always completes.
  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      r_state      <= ST_IDLE;
      r_grant      <= '0;
      r_last_grant <= IDX_W'(NUM_QUEUES - 1);
      r_pkt_count  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_state <= ST_SEND;
            r_grant <= w_next_grant;
          end
        end
        ST_SEND: begin
          if (w_pkt_done) begin
            r_state      <= ST_IDLE;
            r_grant      <= '0;
            r_last_grant <= w_grant_idx;
            r_pkt_count  <= r_pkt_count + PKT_COUNT_WIDTH'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_grant <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nf_sume_xbar_rr_arbiter.sv
// Scoreboard bench for the round-robin arbiter: per-requester source queues
// feed the DUT, and a monitor checks every master-side beat against expectations.
`timescale 1ns/1ps
module tb_nf_sume_xbar_rr_arbiter;

  localparam int NQ = 5;
  localparam int DW = 64;
  localparam int UW = 128;
  localparam int KW = DW / 8;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic [UW-1:0] user;
    logic          last;
  } beat_t;

  typedef struct {
    beat_t         beat;
    logic [NQ-1:0] grant;
    int            gap;
  } exp_t;

  logic             clock = 1'b0;
  logic             aresetN;
  logic [NQ*DW-1:0] sTdata;
  logic [NQ*KW-1:0] sTkeep;
  logic [NQ*UW-1:0] sTuser;
  logic [NQ-1:0]    sTvalid;
  logic [NQ-1:0]    sTlast;
  logic [NQ-1:0]    sTready;
  logic [DW-1:0]    mTdata;
  logic [KW-1:0]    mTkeep;
  logic [UW-1:0]    mTuser;
  logic             mTvalid;
  logic             mTlast;
  logic             mTready;
  logic [NQ-1:0]    portEnable;
  logic [31:0]      pktCount;
  logic [NQ-1:0]    curGrant;

  beat_t srcQ[NQ][$];
  exp_t  expQ[$];
  int    vectors     = 0;
  int    miscompares = 0;
  int    cyc         = 0;
  bit    toggleReady = 1'b0;

  nf_sume_xbar_rr_arbiter #(
    .C_AXIS_DATA_WIDTH  (DW),
    .C_AXIS_TUSER_WIDTH (UW),
    .NUM_QUEUES         (NQ)
  ) dut (
    .axis_aclk     (clock),
    .axis_aresetn  (aresetN),
    .s_axis_tdata  (sTdata),
    .s_axis_tkeep  (sTkeep),
    .s_axis_tuser  (sTuser),
    .s_axis_tvalid (sTvalid),
    .s_axis_tlast  (sTlast),
    .s_axis_tready (sTready),
    .m_axis_tdata  (mTdata),
    .m_axis_tkeep  (mTkeep),
    .m_axis_tuser  (mTuser),
    .m_axis_tvalid (mTvalid),
    .m_axis_tlast  (mTlast),
    .m_axis_tready (mTready),
    .port_enable   (portEnable),
    .pkt_count     (pktCount),
    .cur_grant     (curGrant)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic beat_t mkBeat(int req, int pkt, int b, int nbeats);
    beat_t r;
    r.data = {8'(req), 24'(pkt), 32'(b)};
    r.last = (b == nbeats - 1);
    r.keep = r.last ? KW'(15) : '1;
    r.user = {32'hC0DE0000 | 32'(req), 32'(pkt), 64'(b)};
    return r;
  endfunction

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, want %h", name, act, want);
    end
  endtask

  task automatic applyStimulus(int req, int pkt, int nbeats);
    for (int b = 0; b < nbeats; b++) srcQ[req].push_back(mkBeat(req, pkt, b, nbeats));
  endtask

  task automatic expectBeat(int req, int pkt, int b, int nbeats, int gap);
    exp_t e;
    e.beat  = mkBeat(req, pkt, b, nbeats);
    e.grant = NQ'(1 << req);
    e.gap   = gap;
    expQ.push_back(e);
  endtask

  task automatic expectPkt(int req, int pkt, int nbeats, int firstGap, int restGap);
    for (int b = 0; b < nbeats; b++) expectBeat(req, pkt, b, nbeats, (b == 0) ? firstGap : restGap);
  endtask

  task automatic waitDrain(string name, int budget);
    int n = 0;
    while (expQ.size() != 0 && n < budget) begin
      @(negedge clock);
      n++;
    end
    checkOutput(name, 32'(expQ.size()), 32'd0);
    expQ.delete();
    repeat (2) @(negedge clock);
  endtask

  task automatic waitGrant(string name, logic [NQ-1:0] want, int budget);
    int n = 0;
    while (curGrant !== want && n < budget) begin
      @(negedge clock);
      n++;
    end
    checkOutput(name, 32'(curGrant), 32'(want));
  endtask

  task automatic doReset();
    aresetN = 1'b0;
    for (int i = 0; i < NQ; i++) srcQ[i].delete();
    expQ.delete();
    repeat (3) @(negedge clock);
    aresetN = 1'b1;
    @(negedge clock);
  endtask

  // Source model: retire a beat after each handshake seen before the edge, then present the next.
  initial begin : driver
    logic [NQ-1:0] hs;
    sTdata  = '0;
    sTkeep  = '0;
    sTuser  = '0;
    sTvalid = '0;
    sTlast  = '0;
    mTready = 1'b1;
    forever begin
      @(negedge clock);
      hs = sTvalid & sTready;
      @(posedge clock);
      #1;
      for (int i = 0; i < NQ; i++) begin
        if (hs[i] && srcQ[i].size() > 0) void'(srcQ[i].pop_front());
        if (srcQ[i].size() > 0) begin
          sTvalid[i]           = 1'b1;
          sTdata[i*DW +: DW]   = srcQ[i][0].data;
          sTkeep[i*KW +: KW]   = srcQ[i][0].keep;
          sTuser[i*UW +: UW]   = srcQ[i][0].user;
          sTlast[i]            = srcQ[i][0].last;
        end else begin
          sTvalid[i] = 1'b0;
          sTlast[i]  = 1'b0;
        end
      end
      mTready = toggleReady ? ~mTready : 1'b1;
    end
  end

  initial begin : monitor
    exp_t e;
    int   lastHs = -100;
    int   gap;
    forever begin
      @(negedge clock);
      if (aresetN && mTvalid && mTready) begin
        gap    = cyc - lastHs;
        lastHs = cyc;
        vectors++;
        if (expQ.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL unexpected_beat: got grant=%b data=%h, want no beat", curGrant, mTdata);
        end else begin
          e = expQ.pop_front();
          if (curGrant !== e.grant || mTdata !== e.beat.data || mTkeep !== e.beat.keep ||
              mTuser !== e.beat.user || mTlast !== e.beat.last || (e.gap >= 0 && gap != e.gap)) begin
            miscompares++;
            $display("[TB] FAIL beat_check: got grant=%b data=%h keep=%h user=%h last=%b gap=%0d, want grant=%b data=%h keep=%h user=%h last=%b gap=%0d",
                     curGrant, mTdata, mTkeep, mTuser, mTlast, gap,
                     e.grant, e.beat.data, e.beat.keep, e.beat.user, e.beat.last, e.gap);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, want completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    aresetN    = 1'b0;
    portEnable = '1;

    // Requester valid while reset is held must not leak through.
    applyStimulus(3, 0, 2);
    repeat (3) @(negedge clock);
    checkOutput("rst_tvalid", 32'(mTvalid), 32'd0);
    checkOutput("rst_tready", 32'(sTready), 32'd0);
    checkOutput("rst_grant", 32'(curGrant), 32'd0);
    checkOutput("rst_count", pktCount, 32'd0);
    doReset();
    checkOutput("post_rst_count", pktCount, 32'd0);
    checkOutput("post_rst_grant", 32'(curGrant), 32'd0);

    // Requesters 0 and 2 with 3-beat packets: 0 first, one bubble, then 2.
    applyStimulus(0, 1, 3);
    applyStimulus(2, 1, 3);
    expectPkt(0, 1, 3, -1, 1);
    expectPkt(2, 1, 3, 2, 1);
    waitDrain("t1_drain", 40);
    checkOutput("t1_count", pktCount, 32'd2);

    // All five contending with 1-beat packets: 0..4 twice, every packet 2 cycles apart.
    doReset();
    for (int p = 0; p < 2; p++)
      for (int r = 0; r < NQ; r++) applyStimulus(r, 10 + p, 1);
    for (int p = 0; p < 2; p++)
      for (int r = 0; r < NQ; r++) expectPkt(r, 10 + p, 1, (p == 0 && r == 0) ? -1 : 2, 1);
    waitDrain("t2_drain", 60);
    checkOutput("t2_count", pktCount, 32'd10);

    // Requester 1 under a 1010 downstream ready pattern.
    toggleReady = 1'b1;
    applyStimulus(1, 20, 4);
    expectPkt(1, 20, 4, -1, -1);
    waitGrant("t3_grant", NQ'(5'b00010), 20);
    for (int k = 0; k < 6; k++)
      checkOutput("t3_tready_mirror", 32'(sTready), mTready ? 32'h2 : 32'h0);
    waitDrain("t3_drain", 40);
    toggleReady = 1'b0;
    checkOutput("t3_count", pktCount, 32'd11);

    // Disable requester 3 on beat 2 of its packet; it completes, then stays masked.
    applyStimulus(3, 30, 4);
    expectPkt(3, 30, 4, -1, 1);
    waitGrant("t4_grant", NQ'(5'b01000), 20);
    @(negedge clock);
    portEnable[3] = 1'b0;
    applyStimulus(3, 31, 1);
    applyStimulus(4, 32, 1);
    expectPkt(4, 32, 1, 2, 1);
    waitDrain("t4_drain", 40);
    repeat (6) @(negedge clock);
    checkOutput("t4_masked_grant", 32'(curGrant), 32'd0);
    checkOutput("t4_masked_pending", 32'(srcQ[3].size()), 32'd1);
    portEnable[3] = 1'b1;
    expectPkt(3, 31, 1, -1, 1);
    waitDrain("t4_reenable_drain", 20);
    checkOutput("t4_count", pktCount, 32'd14);

    // Leave last_grant at 1, then reset during beat 2 of a 5-beat packet.
    applyStimulus(1, 39, 1);
    expectPkt(1, 39, 1, -1, 1);
    waitDrain("t5_pre_drain", 20);
    applyStimulus(1, 40, 5);
    expectBeat(1, 40, 0, 5, -1);
    waitGrant("t5_grant", NQ'(5'b00010), 20);
    @(posedge clock);
    #2;
    checkOutput("t5_beat2_valid", 32'(mTvalid), 32'd1);
    aresetN = 1'b0;
    #1;
    checkOutput("t5_rst_tvalid", 32'(mTvalid), 32'd0);
    checkOutput("t5_rst_grant", 32'(curGrant), 32'd0);
    checkOutput("t5_rst_tready", 32'(sTready), 32'd0);
    checkOutput("t5_rst_count", pktCount, 32'd0);
    checkOutput("t5_beats_seen", 32'(expQ.size()), 32'd0);
    @(negedge clock);
    doReset();
    applyStimulus(2, 41, 1);
    applyStimulus(0, 42, 1);
    expectPkt(0, 42, 1, -1, 1);
    expectPkt(2, 41, 1, 2, 1);
    waitDrain("t5_post_drain", 30);
    checkOutput("t5_count", pktCount, 32'd2);

    // Packet counter wrap: preload just below the top, then forward two packets.
    force dut.r_pkt_count = 32'hFFFF_FFFE;
    @(negedge clock);
    release dut.r_pkt_count;
    @(negedge clock);
    applyStimulus(0, 50, 2);
    expectPkt(0, 50, 2, -1, 1);
    waitDrain("t6_drain_a", 20);
    checkOutput("t6_count_max", pktCount, 32'hFFFF_FFFF);
    applyStimulus(3, 51, 1);
    expectPkt(3, 51, 1, -1, 1);
    waitDrain("t6_drain_b", 20);
    checkOutput("t6_count_wrap", pktCount, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
